// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: SLICE bits per clock through a registered ripple carry; start/busy/done handshake.
// Latency NSTEP clocks from accepted start to done; start is ignored while busy, results hold until the next done.
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int NSTEP = WIDTH / SLICE;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("serial_adder_nbit: WIDTH must be >= 2 and an exact multiple of SLICE");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, a_sh_nxt;
    logic [WIDTH-1:0] b_sh, b_sh_nxt;
    logic [WIDTH-1:0] psum, psum_nxt;
    logic             cry, cry_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             msb_a, msb_a_nxt;
    logic             msb_b, msb_b_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] psum_shift;
    logic             last;

    // Each slice result enters at the top, so after NSTEP steps psum holds the sum in place.
    assign slice_res  = {1'b0, a_sh[SLICE-1:0]} + {1'b0, b_sh[SLICE-1:0]} + {{SLICE{1'b0}}, cry};
    assign psum_shift = (psum >> SLICE) | (WIDTH'(slice_res[SLICE-1:0]) << (WIDTH - SLICE));
    assign last       = (cnt == CW'(NSTEP - 1));
    assign busy_out   = (state == RUN);

    always_comb begin
        state_nxt = state;
        a_sh_nxt  = a_sh;
        b_sh_nxt  = b_sh;
        psum_nxt  = psum;
        cry_nxt   = cry;
        cnt_nxt   = cnt;
        msb_a_nxt = msb_a;
        msb_b_nxt = msb_b;
        done_nxt  = 1'b0;
        sum_nxt   = sum_out;
        cout_nxt  = carry_out;
        ovf_nxt   = overflow_out;
        case (state)
            IDLE: begin
                if (start_in) begin
                    a_sh_nxt  = a_in;
                    b_sh_nxt  = b_in;
                    cry_nxt   = carry_in;
                    psum_nxt  = '0;
                    cnt_nxt   = '0;
                    msb_a_nxt = a_in[WIDTH-1];
                    msb_b_nxt = b_in[WIDTH-1];
                    state_nxt = RUN;
                end
            end
            RUN: begin
                a_sh_nxt = a_sh >> SLICE;
                b_sh_nxt = b_sh >> SLICE;
                psum_nxt = psum_shift;
                cry_nxt  = slice_res[SLICE];
                cnt_nxt  = cnt + CW'(1);
                if (last) begin
                    sum_nxt   = psum_shift;
                    cout_nxt  = slice_res[SLICE];
                    ovf_nxt   = (msb_a == msb_b) && (psum_shift[WIDTH-1] != msb_a);
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            psum         <= '0;
            cry          <= 1'b0;
            cnt          <= '0;
            msb_a        <= 1'b0;
            msb_b        <= 1'b0;
            done_out     <= 1'b0;
            sum_out      <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            state        <= state_nxt;
            a_sh         <= a_sh_nxt;
            b_sh         <= b_sh_nxt;
            psum         <= psum_nxt;
            cry          <= cry_nxt;
            cnt          <= cnt_nxt;
            msb_a        <= msb_a_nxt;
            msb_b        <= msb_b_nxt;
            done_out     <= done_nxt;
            sum_out      <= sum_nxt;
            carry_out    <= cout_nxt;
            overflow_out <= ovf_nxt;
        end
    end

endmodule
